// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: LSB-first bit stream in, comma-aligned bytes out.
// Alignment is hunted bit-by-bit, then confirmed by LOCK_COUNT aligned commas.
module serial_parallel_rx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter logic [3:0] LOCK_COUNT = 4'd4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       COMMA_DET,
    output logic       LOCKED
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  sr_r;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_cnt_s;
    logic [3:0]  comma_cnt_r;
    logic [3:0]  comma_cnt_s;
    logic [7:0]  data_out_r;
    logic [7:0]  data_out_s;
    logic        data_valid_r;
    logic        data_valid_s;
    logic        comma_det_r;
    logic        comma_det_s;
    logic        locked_r;
    logic        locked_s;
    logic [7:0]  word_s;
    logic        match_s;

    function automatic logic is_comma(input logic [7:0] w);
        return (w == COMMA);
    endfunction

    // Candidate word includes the bit being sampled on this edge
    assign word_s  = {DATA_IN, sr_r[7:1]};
    assign match_s = is_comma(word_s);

    // Alignment FSM next-state and output decode
    always_comb begin
        next_state_s = state_r;
        bit_cnt_s    = bit_cnt_r + 3'd1;
        comma_cnt_s  = comma_cnt_r;
        data_out_s   = data_out_r;
        data_valid_s = 1'b0;
        comma_det_s  = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                bit_cnt_s = 3'd0;
                if (match_s) begin
                    comma_cnt_s  = 4'd1;
                    next_state_s = (LOCK_COUNT == 4'd1) ? ST_LOCKED : ST_ALIGN;
                end else begin
                    next_state_s = ST_SEARCH;
                end
            end
            ST_ALIGN: begin
                if (bit_cnt_r == 3'd7) begin
                    if (match_s) begin
                        comma_cnt_s = comma_cnt_r + 4'd1;
                        if ((comma_cnt_r + 4'd1) == LOCK_COUNT) begin
                            next_state_s = ST_LOCKED;
                        end else begin
                            next_state_s = ST_ALIGN;
                        end
                    end else begin
                        // Hunt resumes on the next bit; bit_cnt wraps to 0 anyway
                        comma_cnt_s  = 4'd0;
                        next_state_s = ST_SEARCH;
                    end
                end else begin
                    next_state_s = ST_ALIGN;
                end
            end
            ST_LOCKED: begin
                if (bit_cnt_r == 3'd7) begin
                    data_out_s = word_s;
                    if (match_s) begin
                        comma_det_s = 1'b1;
                    end else begin
                        data_valid_s = 1'b1;
                    end
                end else begin
                    data_out_s = data_out_r;
                end
            end
            default: begin
                next_state_s = ST_SEARCH;
                bit_cnt_s    = 3'd0;
                comma_cnt_s  = 4'd0;
            end
        endcase
        locked_s = (next_state_s == ST_LOCKED);
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= ST_SEARCH;
            sr_r         <= 8'h00;
            bit_cnt_r    <= 3'd0;
            comma_cnt_r  <= 4'd0;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            comma_det_r  <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            sr_r         <= word_s;
            bit_cnt_r    <= bit_cnt_s;
            comma_cnt_r  <= comma_cnt_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            comma_det_r  <= comma_det_s;
            locked_r     <= locked_s;
        end
    end

    assign DATA_OUT   = data_out_r;
    assign DATA_VALID = data_valid_r;
    assign COMMA_DET  = comma_det_r;
    assign LOCKED     = locked_r;

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: default instance (LOCK_COUNT=4)
// plus a LOCK_COUNT=1 instance sharing the same serial line.
module tb_serial_parallel_rx;

    logic       CLK;
    logic       RESET;
    logic       DATA_IN;
    logic [7:0] dout0_s;
    logic       dv0_s;
    logic       cd0_s;
    logic       lk0_s;
    logic [7:0] dout1_s;
    logic       dv1_s;
    logic       cd1_s;
    logic       lk1_s;

    int n_vec;
    int n_err;
    int vld_seen;
    int cd_seen;
    int vld1_seen;

    serial_parallel_rx dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (dout0_s),
        .DATA_VALID (dv0_s),
        .COMMA_DET  (cd0_s),
        .LOCKED     (lk0_s)
    );

    serial_parallel_rx #(.COMMA(8'hBC), .LOCK_COUNT(4'd1)) dut1 (
        .CLK        (CLK),
        .RESET      (RESET),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (dout1_s),
        .DATA_VALID (dv1_s),
        .COMMA_DET  (cd1_s),
        .LOCKED     (lk1_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive on negedge, observe just after the sampling posedge
    task automatic send_bit(input logic b);
        @(negedge CLK);
        DATA_IN = b;
        @(posedge CLK);
        #1;
        if (dv0_s) vld_seen++;
        if (cd0_s) cd_seen++;
        if (dv1_s) vld1_seen++;
        if (dv0_s && cd0_s) check_vec("strobe_excl", {7'd0, cd0_s}, 8'h00);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET   = 1'b1;
        DATA_IN = 1'b0;
        @(posedge CLK);
        #1;
        check_vec("rst_dout",   dout0_s, 8'h00);
        check_vec("rst_valid",  {7'd0, dv0_s}, 8'h00);
        check_vec("rst_comma",  {7'd0, cd0_s}, 8'h00);
        check_vec("rst_locked", {7'd0, lk0_s}, 8'h00);
        RESET     = 1'b0;
        vld_seen  = 0;
        cd_seen   = 0;
        vld1_seen = 0;
    endtask

    task automatic send_commas(input int n);
        for (int i = 0; i < n; i++) send_byte(8'hBC);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        vld_seen = 0; cd_seen = 0; vld1_seen = 0;
        RESET = 1'b1;
        DATA_IN = 1'b0;

        // Aligned lock with defaults
        do_reset();
        send_commas(3);
        send_bits(8'hBC, 7);
        check_vec("t1_lock_bit30", {7'd0, lk0_s}, 8'h00);
        send_bit(1'b1);
        check_vec("t1_lock_bit31", {7'd0, lk0_s}, 8'h01);
        check_vec("t1_no_out",     dout0_s, 8'h00);
        send_byte(8'h5A);
        check_vec("t1_valid",  {7'd0, dv0_s}, 8'h01);
        check_vec("t1_dout",   dout0_s, 8'h5A);
        send_bit(1'b0);
        check_vec("t1_pulse1", {7'd0, dv0_s}, 8'h00);
        check_vec("t1_hold",   dout0_s, 8'h5A);
        check_vec("t1_ncd",    cd_seen[7:0], 8'h00);
        check_vec("t1_nvld",   vld_seen[7:0], 8'h01);

        // Misaligned start
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_commas(4);
        check_vec("t2_lock", {7'd0, lk0_s}, 8'h01);
        send_byte(8'hA5);
        check_vec("t2_v1",  {7'd0, dv0_s}, 8'h01);
        check_vec("t2_d1",  dout0_s, 8'hA5);
        send_byte(8'h3C);
        check_vec("t2_v2",  {7'd0, dv0_s}, 8'h01);
        check_vec("t2_d2",  dout0_s, 8'h3C);
        check_vec("t2_cnt", vld_seen[7:0], 8'h02);

        // Broken sequence
        do_reset();
        send_commas(2);
        send_byte(8'h00);
        check_vec("t3_unlock", {7'd0, lk0_s}, 8'h00);
        send_commas(3);
        check_vec("t3_lock3", {7'd0, lk0_s}, 8'h00);
        send_commas(1);
        check_vec("t3_lock4", {7'd0, lk0_s}, 8'h01);
        check_vec("t3_none",  vld_seen[7:0], 8'h00);
        send_byte(8'h77);
        check_vec("t3_valid", {7'd0, dv0_s}, 8'h01);
        check_vec("t3_dout",  dout0_s, 8'h77);
        check_vec("t3_cnt",   vld_seen[7:0], 8'h01);

        // Comma while locked
        do_reset();
        send_commas(4);
        send_byte(8'h11);
        check_vec("t4_v11", {7'd0, dv0_s}, 8'h01);
        check_vec("t4_d11", dout0_s, 8'h11);
        send_byte(8'hBC);
        check_vec("t4_cd",   {7'd0, cd0_s}, 8'h01);
        check_vec("t4_nv",   {7'd0, dv0_s}, 8'h00);
        check_vec("t4_dbc",  dout0_s, 8'hBC);
        send_byte(8'h22);
        check_vec("t4_v22",  {7'd0, dv0_s}, 8'h01);
        check_vec("t4_ncd",  {7'd0, cd0_s}, 8'h00);
        check_vec("t4_d22",  dout0_s, 8'h22);
        check_vec("t4_vcnt", vld_seen[7:0], 8'h02);
        check_vec("t4_ccnt", cd_seen[7:0], 8'h01);

        // Reset mid-word while locked
        do_reset();
        send_commas(4);
        send_byte(8'h11);
        send_bits(8'h33, 4);
        do_reset();
        send_commas(3);
        check_vec("t5_nolock", {7'd0, lk0_s}, 8'h00);
        send_commas(1);
        check_vec("t5_relock", {7'd0, lk0_s}, 8'h01);
        send_byte(8'h44);
        check_vec("t5_valid",  {7'd0, dv0_s}, 8'h01);
        check_vec("t5_dout",   dout0_s, 8'h44);

        // LOCK_COUNT = 1 instance
        do_reset();
        send_bits(8'hBC, 7);
        check_vec("t6_lock_pre", {7'd0, lk1_s}, 8'h00);
        send_bit(1'b1);
        check_vec("t6_lock",     {7'd0, lk1_s}, 8'h01);
        check_vec("t6_nov",      {7'd0, dv1_s}, 8'h00);
        send_byte(8'h99);
        check_vec("t6_valid",    {7'd0, dv1_s}, 8'h01);
        check_vec("t6_dout",     dout1_s, 8'h99);
        check_vec("t6_cnt",      vld1_seen[7:0], 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
